// File: rtl/gaussian_pkg.sv
// Shared constants for the Gaussian-blur MAC: 5x5 integer kernel, its sum, and FSM states.
package gaussian_pkg;

    localparam int unsigned KERNEL_DIM  = 5;
    localparam int unsigned KERNEL_TAPS = 25;
    localparam int unsigned KERNEL_SUM  = 159;

    localparam logic [3:0] KERNEL_COEF [KERNEL_TAPS] = '{
        4'd2, 4'd4,  4'd5,  4'd4,  4'd2,
        4'd4, 4'd9,  4'd12, 4'd9,  4'd4,
        4'd5, 4'd12, 4'd15, 4'd12, 4'd5,
        4'd4, 4'd9,  4'd12, 4'd9,  4'd4,
        4'd2, 4'd4,  4'd5,  4'd4,  4'd2
    };

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        OUTPUT = 2'd3
    } state_e;

    // Out-of-range beat indices map to a zero weight rather than an undefined lookup.
    function automatic logic [3:0] kernel_coef(input logic [4:0] idx);
        return (32'(idx) < KERNEL_TAPS) ? KERNEL_COEF[idx] : 4'd0;
    endfunction

endpackage

// File: rtl/gaussian_mac.sv
// Serial 5x5 Gaussian multiply-accumulate; hands the weighted sum to an external divider
// and presents the saturated quotient as one blurred pixel.
module gaussian_mac
    import gaussian_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH   = 8,
    parameter int unsigned SUM_WIDTH     = 16,
    parameter int unsigned DIVISOR_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIXEL_WIDTH-1:0]   in_pixel,
    output logic                     div_valid_in,
    output logic [SUM_WIDTH-1:0]     div_dividend,
    output logic [DIVISOR_WIDTH-1:0] div_divisor,
    input  logic [SUM_WIDTH-1:0]     div_quotient,
    input  logic                     div_valid_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PIXEL_WIDTH-1:0]   out_pixel
);

    localparam int unsigned          PROD_WIDTH = PIXEL_WIDTH + 4;
    localparam logic [4:0]           LAST_BEAT  = 5'(KERNEL_TAPS - 1);
    localparam logic [SUM_WIDTH-1:0] PIXEL_MAX  = SUM_WIDTH'({PIXEL_WIDTH{1'b1}});

    state_e                state;
    logic [4:0]            cnt;
    logic [SUM_WIDTH-1:0]  acc;
    logic [PROD_WIDTH-1:0] product;
    logic [SUM_WIDTH-1:0]  acc_next;

    assign product     = PROD_WIDTH'(in_pixel) * PROD_WIDTH'(kernel_coef(cnt));
    assign acc_next    = acc + SUM_WIDTH'(product);
    assign div_divisor = DIVISOR_WIDTH'(KERNEL_SUM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ACCUM;
            cnt          <= '0;
            acc          <= '0;
            in_ready     <= 1'b1;
            div_valid_in <= 1'b0;
            div_dividend <= '0;
            out_valid    <= 1'b0;
            out_pixel    <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc <= acc_next;
                        if (cnt == LAST_BEAT) begin
                            // Last tap: launch the divide with the completed sum next cycle.
                            cnt          <= '0;
                            div_dividend <= acc_next;
                            div_valid_in <= 1'b1;
                            in_ready     <= 1'b0;
                            state        <= ISSUE;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                ISSUE: begin
                    div_valid_in <= 1'b0;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (div_valid_out) begin
                        out_pixel <= (div_quotient > PIXEL_MAX) ? '1
                                                                : div_quotient[PIXEL_WIDTH-1:0];
                        out_valid <= 1'b1;
                        acc       <= '0;
                        state     <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state        <= ACCUM;
                    cnt          <= '0;
                    acc          <= '0;
                    in_ready     <= 1'b1;
                    div_valid_in <= 1'b0;
                    out_valid    <= 1'b0;
                end
            endcase
        end
    end

endmodule
